game_frame_ctrl: RTL and testbench
==================================

GAME_FRAME_CTRL -- requirements
Module: game_frame_ctrl

Interface
REQ-001 Parameter LIVES, default 3, hits each player can absorb per game (legal range 1..3).
REQ-002 Parameter HOLD_FRAMES, default 300, video frames a win screen is held before returning to the initial screen (legal range 1..65535).
REQ-003 clk  input  1  pixel/system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start_btn  input  1  debounced, synchronous start button level.
REQ-006 frame_tick  input  1  one-cycle pulse at start of vertical blanking.
REQ-007 tank_hit  input  1  one-cycle pulse: train bullet struck tank.
REQ-008 train_hit  input  1  one-cycle pulse: tank bullet struck train.
REQ-009 frame1  output  1  initial screen select.
REQ-010 frame2  output  1  map/game screen select.
REQ-011 frame3  output  1  tank-win screen select.
REQ-012 frame4  output  1  train-win screen select.
REQ-013 tank_lives  output  2  remaining tank lives.
REQ-014 train_lives  output  2  remaining train lives.
REQ-015 game_active  output  1  high while state is PLAY.
REQ-016 round_reset  output  1  one-cycle pulse telling bot/bullet logic to reload start positions.

Function
REQ-017 Control FSM SHALL have exactly four states, INIT, PLAY, TANK_WIN and TRAIN_WIN, and every output SHALL be registered.
REQ-018 start_btn rising edge SHALL be detected with a one-cycle pulse from a registered copy of start_btn.
REQ-019 INIT: start edge -> PLAY next cycle; same edge reloads both lives to LIVES and pulses round_reset for exactly one cycle.
REQ-020 INIT, TANK_WIN, TRAIN_WIN: tank_hit and train_hit SHALL be ignored; lives hold their values.
REQ-021 PLAY: each tank_hit pulse SHALL decrement tank_lives by 1, each train_hit pulse SHALL decrement train_lives by 1; both may decrement in the same cycle; lives SHALL saturate at 0.
REQ-022 PLAY: hit taking tank_lives 1->0 alone -> TRAIN_WIN; hit taking train_lives 1->0 alone -> TANK_WIN; transition next cycle.
REQ-023 PLAY: both reaching 0 in the same cycle (tie) -> stay PLAY, reload both lives to LIVES, pulse round_reset one cycle.
REQ-024 PLAY: start_btn edges SHALL be ignored.
REQ-025 TANK_WIN/TRAIN_WIN: 16-bit hold counter cleared on entry, incremented on each frame_tick; on frame_tick with counter == HOLD_FRAMES-1 -> INIT next cycle, counter cleared.
REQ-026 Start edges during TANK_WIN/TRAIN_WIN SHALL be ignored, not queued; a button still held on return to INIT SHALL NOT start a game until released and re-pressed.
REQ-027 frame1..frame4 SHALL be one-hot at all times and SHALL be updated only on cycles where frame_tick=1, loaded from the FSM state of that cycle (INIT->frame1, PLAY->frame2, TANK_WIN->frame3, TRAIN_WIN->frame4).
REQ-028 Frame-select latency: state change visible on frame outputs on the cycle after the next frame_tick; frame_tick coincident with the transition cycle SHALL load the old state.
REQ-029 game_active and lives outputs SHALL follow the FSM immediately (no frame_tick gating).
REQ-030 frame_tick coincident with hit or start edge: both events processed in the same cycle, no loss.

Reset
REQ-031 reset_n low SHALL asynchronously force: state INIT; frame1=1, frame2=frame3=frame4=0; tank_lives=train_lives=LIVES; hold counter 0; round_reset=0; game_active=0.
REQ-032 Start-edge register SHALL reset to 1 so a button held through reset deassertion does not start a game.
REQ-033 reset_n asserted mid-PLAY or mid-hold SHALL abort immediately with no round_reset pulse.

Verification
REQ-034 Reset, release, pulse start_btn high 3 cycles -> one round_reset pulse, game_active=1 next cycle, lives 3/3; frame2 rises one cycle after next frame_tick.
REQ-035 In PLAY, 3 train_hit pulses -> train_lives 2,1,0; state TANK_WIN; frame3 after next frame_tick; after 300 frame_ticks frame1 after following frame_tick.
REQ-036 In PLAY with lives 1/1, tank_hit and train_hit same cycle -> lives 3/3, round_reset pulse, frame2 unchanged, game_active stays 1.
REQ-037 start_btn held high through reset and through a win hold -> no game start until start_btn goes low then high.
REQ-038 Hits in INIT and during TRAIN_WIN -> lives unchanged; reset_n low mid-PLAY -> frame1=1 and lives 3/3 without waiting for frame_tick.

Source files
------------

// File: rtl/game_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_frame_ctrl
// Purpose  : Game flow controller for a tank-vs-train game. The controller
//            sequences the screens INIT -> PLAY -> TANK_WIN / TRAIN_WIN ->
//            INIT. It tracks the lives of both players and holds the win
//            screen for a fixed number of video frames. Screen selects change
//            only on frame_tick, so a screen never switches in mid-frame.
// Ports    : clk          - system/pixel clock; all state changes on its rising edge
//            reset_n      - asynchronous active-low reset
//            start_btn    - debounced start button level
//            frame_tick   - one-cycle pulse at the start of vertical blanking
//            tank_hit     - one-cycle pulse: a train bullet struck the tank
//            train_hit    - one-cycle pulse: a tank bullet struck the train
//            frame1..4    - one-hot screen select (init/map/tank-win/train-win)
//            tank_lives   - remaining tank lives
//            train_lives  - remaining train lives
//            game_active  - high while the game is in play
//            round_reset  - one-cycle pulse that reloads the start positions
// Revision : 1.0 - initial release
// ============================================================================
module game_frame_ctrl #(
  parameter int LIVES       = 3,    // 1..3
  parameter int HOLD_FRAMES = 300   // 1..65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       tank_hit,
  input  logic       train_hit,
  output logic       frame1,
  output logic       frame2,
  output logic       frame3,
  output logic       frame4,
  output logic [1:0] tank_lives,
  output logic [1:0] train_lives,
  output logic       game_active,
  output logic       round_reset
);

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_TANK_WIN  = 2'd2,
    ST_TRAIN_WIN = 2'd3
  } state_t;

  localparam logic [1:0]  c_lives_full = 2'(LIVES);
  localparam logic [15:0] c_hold_last  = 16'(HOLD_FRAMES - 1);

  state_t      r_state;
  logic        r_start_q;
  logic [15:0] r_hold_cnt;

  logic       w_start_edge;
  logic       w_tank_out;
  logic       w_train_out;
  logic [1:0] w_tank_next;
  logic [1:0] w_train_next;

  // The delayed copy resets to 1, so a button that is held through reset or
  // through a win hold produces no edge until it is released and pressed again.
  assign w_start_edge = start_btn & ~r_start_q;

  // Decrement with saturation at zero.
  assign w_tank_next  = (tank_hit  && tank_lives  != 2'd0) ? tank_lives  - 2'd1 : tank_lives;
  assign w_train_next = (train_hit && train_lives != 2'd0) ? train_lives - 2'd1 : train_lives;

  // A hit is lethal when it takes the player's lives from 1 to 0.
  assign w_tank_out  = tank_hit  && (tank_lives  == 2'd1);
  assign w_train_out = train_hit && (train_lives == 2'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_INIT;
      r_start_q   <= 1'b1;
      r_hold_cnt  <= 16'd0;
      frame1      <= 1'b1;
      frame2      <= 1'b0;
      frame3      <= 1'b0;
      frame4      <= 1'b0;
      tank_lives  <= c_lives_full;
      train_lives <= c_lives_full;
      game_active <= 1'b0;
      round_reset <= 1'b0;
    end else begin
      r_start_q   <= start_btn;
      round_reset <= 1'b0;

      // The screen select samples the state of the current cycle. A transition
      // that happens on this same edge shows up only at the next frame_tick.
      if (frame_tick) begin
        frame1 <= (r_state == ST_INIT);
        frame2 <= (r_state == ST_PLAY);
        frame3 <= (r_state == ST_TANK_WIN);
        frame4 <= (r_state == ST_TRAIN_WIN);
      end

      case (r_state)
        ST_INIT: begin
          if (w_start_edge) begin
            r_state     <= ST_PLAY;
            tank_lives  <= c_lives_full;
            train_lives <= c_lives_full;
            round_reset <= 1'b1;
            game_active <= 1'b1;
          end
        end

        ST_PLAY: begin
          if (w_tank_out && w_train_out) begin
            // Tie: replay the round with full lives.
            tank_lives  <= c_lives_full;
            train_lives <= c_lives_full;
            round_reset <= 1'b1;
          end else if (w_tank_out) begin
            tank_lives  <= w_tank_next;
            train_lives <= w_train_next;
            r_state     <= ST_TRAIN_WIN;
            r_hold_cnt  <= 16'd0;
            game_active <= 1'b0;
          end else if (w_train_out) begin
            tank_lives  <= w_tank_next;
            train_lives <= w_train_next;
            r_state     <= ST_TANK_WIN;
            r_hold_cnt  <= 16'd0;
            game_active <= 1'b0;
          end else begin
            tank_lives  <= w_tank_next;
            train_lives <= w_train_next;
          end
        end

        ST_TANK_WIN, ST_TRAIN_WIN: begin
          if (frame_tick) begin
            if (r_hold_cnt == c_hold_last) begin
              r_state    <= ST_INIT;
              r_hold_cnt <= 16'd0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 16'd1;
            end
          end
        end

        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_frame_ctrl
// Purpose  : Directed testbench for game_frame_ctrl with the default
//            parameters (LIVES=3, HOLD_FRAMES=300).
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_btn;
  logic       frame_tick;
  logic       tank_hit;
  logic       train_hit;
  logic       frame1, frame2, frame3, frame4;
  logic [1:0] tank_lives, train_lives;
  logic       game_active;
  logic       round_reset;

  int checks   = 0;
  int failures = 0;

  game_frame_ctrl #(.LIVES(3), .HOLD_FRAMES(300)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_btn   (start_btn),
    .frame_tick  (frame_tick),
    .tank_hit    (tank_hit),
    .train_hit   (train_hit),
    .frame1      (frame1),
    .frame2      (frame2),
    .frame3      (frame3),
    .frame4      (frame4),
    .tank_lives  (tank_lives),
    .train_lives (train_lives),
    .game_active (game_active),
    .round_reset (round_reset)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] frames();
    return {28'd0, frame1, frame2, frame3, frame4};
  endfunction

  function automatic logic [31:0] lives();
    return {28'd0, tank_lives, train_lives};
  endfunction

  initial begin
    reset_n = 1'b0; start_btn = 1'b0; frame_tick = 1'b0;
    tank_hit = 1'b0; train_hit = 1'b0;
    tick(); tick();
    check("rst_frames", frames(), 32'h8);
    check("rst_lives", lives(), 32'hF);
    check("rst_active", {31'd0, game_active}, 32'd0);
    check("rst_rreset", {31'd0, round_reset}, 32'd0);

    // Start: button high for 3 cycles
    reset_n = 1'b1; tick();
    start_btn = 1'b1; tick();
    check("start_rreset", {31'd0, round_reset}, 32'd1);
    check("start_active", {31'd0, game_active}, 32'd1);
    check("start_lives", lives(), 32'hF);
    tick();
    check("start_rreset_one", {31'd0, round_reset}, 32'd0);
    tick();
    start_btn = 1'b0;
    check("start_frames_wait", frames(), 32'h8);
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("play_frames", frames(), 32'h4);

    // Three train hits, with the last one coincident with a frame_tick
    train_hit = 1'b1; tick(); train_hit = 1'b0;
    check("train_hit1", lives(), 32'hE);
    train_hit = 1'b1; tick(); train_hit = 1'b0;
    check("train_hit2", lives(), 32'hD);
    train_hit = 1'b1; frame_tick = 1'b1; tick(); train_hit = 1'b0; frame_tick = 1'b0;
    check("train_hit3", lives(), 32'hC);
    check("tankwin_active", {31'd0, game_active}, 32'd0);
    check("tankwin_frames_old", frames(), 32'h4);
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("tankwin_frames", frames(), 32'h2);

    // Button held during the hold; hits are ignored
    start_btn = 1'b1;
    tank_hit = 1'b1; tick(); tank_hit = 1'b0;
    check("tankwin_hit_ignored", lives(), 32'hC);
    for (int i = 0; i < 298; i++) begin
      frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
    end
    check("hold_299_frames", frames(), 32'h2);
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("hold_300_frames_old", frames(), 32'h2);
    tick();
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("init_frames", frames(), 32'h8);
    tick(); tick();
    check("held_no_start", {31'd0, game_active}, 32'd0);
    check("held_no_rreset", {31'd0, round_reset}, 32'd0);

    // Hits in INIT do not change lives
    tank_hit = 1'b1; train_hit = 1'b1; tick(); tank_hit = 1'b0; train_hit = 1'b0;
    check("init_hit_ignored", lives(), 32'hC);

    // Release and press again
    start_btn = 1'b0; tick();
    start_btn = 1'b1; tick();
    check("restart_active", {31'd0, game_active}, 32'd1);
    check("restart_rreset", {31'd0, round_reset}, 32'd1);
    check("restart_lives", lives(), 32'hF);
    start_btn = 1'b0;
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("restart_frames", frames(), 32'h4);

    // A start edge during PLAY is ignored
    tick();
    start_btn = 1'b1; tick();
    check("play_start_ignored", {31'd0, round_reset}, 32'd0);
    check("play_start_lives", lives(), 32'hF);
    start_btn = 1'b0;

    // Tie: both players reach 0 on the same cycle
    tank_hit = 1'b1; train_hit = 1'b1; tick();
    check("both_hit1", lives(), 32'hA);
    tick();
    check("both_hit2", lives(), 32'h5);
    tick(); tank_hit = 1'b0; train_hit = 1'b0;
    check("tie_lives", lives(), 32'hF);
    check("tie_rreset", {31'd0, round_reset}, 32'd1);
    check("tie_active", {31'd0, game_active}, 32'd1);
    check("tie_frames", frames(), 32'h4);
    tick();
    check("tie_rreset_one", {31'd0, round_reset}, 32'd0);

    // Tank loses: TRAIN_WIN
    tank_hit = 1'b1; tick(); tick(); tick(); tank_hit = 1'b0;
    check("trainwin_lives", lives(), 32'h3);
    check("trainwin_active", {31'd0, game_active}, 32'd0);
    train_hit = 1'b1; tick(); train_hit = 1'b0;
    check("trainwin_hit_ignored", lives(), 32'h3);
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("trainwin_frames", frames(), 32'h1);

    // Reset during the hold aborts immediately
    reset_n = 1'b0; #2;
    check("holdrst_frames", frames(), 32'h8);
    check("holdrst_lives", lives(), 32'hF);
    tick();
    reset_n = 1'b1; tick();
    start_btn = 1'b1; tick();
    check("g3_active", {31'd0, game_active}, 32'd1);
    start_btn = 1'b0;
    tank_hit = 1'b1; tick(); tank_hit = 1'b0;
    check("g3_tank_hit", lives(), 32'hB);
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    check("g3_frames", frames(), 32'h4);

    // Reset mid-PLAY with the button held through reset release
    start_btn = 1'b1;
    reset_n = 1'b0; #2;
    check("playrst_frames", frames(), 32'h8);
    check("playrst_lives", lives(), 32'hF);
    check("playrst_active", {31'd0, game_active}, 32'd0);
    check("playrst_rreset", {31'd0, round_reset}, 32'd0);
    tick(); tick();
    reset_n = 1'b1; tick(); tick(); tick();
    check("rst_held_no_start", {31'd0, game_active}, 32'd0);
    start_btn = 1'b0; tick();
    start_btn = 1'b1; tick();
    check("rst_repress_start", {31'd0, game_active}, 32'd1);
    start_btn = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
